// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Parametrised single-clock FIFO. Every one of the DEPTH entries can hold data.
// It provides an occupancy count, programmable almost-full and almost-empty flags,
// and sticky overflow and underflow flags.
//
// Compile-time option:
//   FIFO_FWFT_EN  first-word fall-through. data_out shows the head entry
//                 combinationally, and rd_valid is !empty. When the macro is
//                 undefined, reads are registered and rd_valid is a one-cycle strobe.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   write         push request, with data_in as the push data
//   read          pop request, with data_out as the pop data
//   rd_valid      data_out holds a newly popped word (standard mode),
//                 or the head is valid (FWFT mode)
//   full/empty    count == DEPTH / count == 0
//   almost_full   count >= AFULL_THRESH
//   almost_empty  count <= AEMPTY_THRESH
//   count         occupancy, 0..DEPTH
//   overflow      sticky: a write was rejected because the FIFO was full
//   underflow     sticky: a read was made while the FIFO was empty
//   clear_err     synchronous clear of overflow and underflow
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned AFULL_THRESH  = DEPTH - 4,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    read,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clear_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Each pointer carries an extra MSB that acts as a wrap bit.
    // The low AW bits roll over on their own, so no modulo logic is needed.
    logic [CW-1:0]          wr_ptr;
    logic [CW-1:0]          rd_ptr;
    logic [CW-1:0]          wr_ptr_nxt;
    logic [CW-1:0]          rd_ptr_nxt;
    logic [CW-1:0]          count_nxt;
    logic                   wr_en;
    logic                   rd_en;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    // Decide which operations are accepted and compute the next pointers and count.
    // A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
    always_comb begin
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;

        rd_en = read && !empty;
        wr_en = write && (!full || rd_en);

        if (wr_en) begin
            wr_ptr_nxt = wr_ptr + CW'(1);
        end
        if (rd_en) begin
            rd_ptr_nxt = rd_ptr + CW'(1);
        end

        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers, occupancy and status flags.
    // The flags are computed from the next-state values,
    // so they change on the same edge as count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            full         <= (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                            (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
            empty        <= (wr_ptr_nxt == rd_ptr_nxt);
            almost_full  <= (count_nxt >= CW'(AFULL_THRESH));
            almost_empty <= (count_nxt <= CW'(AEMPTY_THRESH));
        end
    end

    // Sticky error flags. A new error event takes priority over clear_err.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write && !wr_en) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end

            if (read && !rd_en) begin
                underflow <= 1'b1;
            end else if (clear_err) begin
                underflow <= 1'b0;
            end
        end
    end

    // Storage array. Its contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    // The head entry is always presented on data_out; a read pops it.
    assign data_out = mem[rd_ptr[AW-1:0]];
    assign rd_valid = !empty;
`else
    // Registered read. data_out holds its value between pops,
    // and rd_valid pulses for one cycle after each pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                data_out <= mem[rd_ptr[AW-1:0]];
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param.
// Configuration: DEPTH=8, AFULL_THRESH=4, AEMPTY_THRESH=2.
// The table below gives the expected count and error flags for each step.
// A reference queue supplies the expected pop data.
module tb_sync_fifo_param;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AFT   = 4;
    localparam int unsigned AET   = 2;

    logic          clk;
    logic          reset_n;
    logic          write;
    logic [DW-1:0] data_in;
    logic          read;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [3:0]    count;
    logic          overflow;
    logic          underflow;
    logic          clear_err;

    sync_fifo_param #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFT),
        .AEMPTY_THRESH(AET)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .write       (write),
        .data_in     (data_in),
        .read        (read),
        .data_out    (data_out),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .clear_err   (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          w;
        logic [DW-1:0] d;
        logic          r;
        logic          c;
        int            cnt;
        logic          ovf;
        logic          udf;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] mq[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] last_data;
    int            passed;
    int            total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic void add(input logic w, input logic [DW-1:0] d, input logic r,
                                input logic c, input int cnt, input logic ovf, input logic udf);
        vec_t v;
        v.w = w; v.d = d; v.r = r; v.c = c; v.cnt = cnt; v.ovf = ovf; v.udf = udf;
        vecs.push_back(v);
    endfunction

    // Check every status output against an expected occupancy and expected error flags.
    task automatic chk_status(input string tag, input int cnt, input logic ovf, input logic udf);
        chk({tag, " count"},        32'(count),        32'(cnt));
        chk({tag, " full"},         32'(full),         32'(cnt == int'(DEPTH)));
        chk({tag, " empty"},        32'(empty),        32'(cnt == 0));
        chk({tag, " almost_full"},  32'(almost_full),  32'(cnt >= int'(AFT)));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(cnt <= int'(AET)));
        chk({tag, " overflow"},     32'(overflow),     32'(ovf));
        chk({tag, " underflow"},    32'(underflow),    32'(udf));
    endtask

    // Apply one cycle of stimulus, update the reference queue, then check after the edge.
    task automatic do_step(input vec_t v, input int idx);
        logic  rd_ok;
        logic  wr_ok;
        string tag;
        tag   = $sformatf("step%0d", idx);
        rd_ok = v.r && (mq.size() != 0);
        wr_ok = v.w && ((mq.size() < DEPTH) || rd_ok);
        if (rd_ok) sb.push_back(mq.pop_front());
        if (wr_ok) mq.push_back(v.d);

        write     = v.w;
        data_in   = v.d;
        read      = v.r;
        clear_err = v.c;
        @(posedge clk);
        #1;
        write     = 1'b0;
        read      = 1'b0;
        clear_err = 1'b0;
        data_in   = '0;

        chk_status(tag, v.cnt, v.ovf, v.udf);
`ifdef FIFO_FWFT_EN
        chk({tag, " rd_valid"}, 32'(rd_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk({tag, " head"}, 32'(data_out), 32'(mq[0]));
        sb.delete();
`else
        chk({tag, " rd_valid"}, 32'(rd_valid), 32'(rd_ok));
        if (rd_ok) begin
            last_data = sb.pop_front();
            chk({tag, " data_out"}, 32'(data_out), 32'(last_data));
        end else begin
            chk({tag, " data_hold"}, 32'(data_out), 32'(last_data));
        end
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        passed    = 0;
        total     = 0;
        last_data = '0;
        write     = 1'b0;
        read      = 1'b0;
        clear_err = 1'b0;
        data_in   = '0;
        reset_n   = 1'b0;

        // Fill to full, overflow, drain, underflow, clear.
        for (int i = 0; i < 8; i++) add(1'b1, DW'(i + 1), 1'b0, 1'b0, i + 1, 1'b0, 1'b0);
        add(1'b1, 8'h09, 1'b0, 1'b0, 8, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) add(1'b0, 8'h00, 1'b1, 1'b0, 7 - i, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        // Refill, write and read together while full, then drain across the pointer wrap.
        for (int i = 0; i < 8; i++) add(1'b1, DW'(8'h10 + i), 1'b0, 1'b0, i + 1, 1'b0, 1'b0);
        add(1'b1, 8'hAA, 1'b1, 1'b0, 8, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) add(1'b0, 8'h00, 1'b1, 1'b0, 7 - i, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        // Write and read together while empty; also a clear in the same cycle as an error event.
        add(1'b1, 8'h33, 1'b1, 1'b0, 1, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0);

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk_status("reset", 0, 1'b0, 1'b0);
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
`ifndef FIFO_FWFT_EN
        chk("reset data_out", 32'(data_out), 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) do_step(vecs[i], i);

        // Mid-stream asynchronous reset with five entries held.
        for (int i = 0; i < 5; i++) begin
            vec_t v;
            v.w = 1'b1; v.d = DW'(8'h41 + i); v.r = 1'b0; v.c = 1'b0;
            v.cnt = i + 1; v.ovf = 1'b0; v.udf = 1'b0;
            do_step(v, 100 + i);
        end
        reset_n = 1'b0;
        #1;
        chk_status("async_reset", 0, 1'b0, 1'b0);
        chk("async_reset rd_valid", 32'(rd_valid), 32'd0);
`ifndef FIFO_FWFT_EN
        chk("async_reset data_out", 32'(data_out), 32'd0);
`endif
        mq.delete();
        sb.delete();
        last_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        begin
            vec_t v;
            v.w = 1'b1; v.d = 8'h5A; v.r = 1'b0; v.c = 1'b0;
            v.cnt = 1; v.ovf = 1'b0; v.udf = 1'b0;
            do_step(v, 200);
            v.w = 1'b0; v.d = 8'h00; v.r = 1'b1; v.cnt = 0;
            do_step(v, 201);
            v.r = 1'b0;
            do_step(v, 202);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO and the next generation of the byte FIFO used between the UART/bus front ends and the core datapath. Adds configurable data width and depth, full-capacity storage (all DEPTH entries usable), an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a registered read-valid strobe. An optional first-word-fall-through mode is selected at compile time.

## Interface
- DATA_WIDTH, 8, width of each entry in bits (1..64)
- DEPTH, 1024, number of entries; power of two, 4..4096
- AFULL_THRESH, DEPTH-4, almost_full asserts when count >= this value
- AEMPTY_THRESH, 4, almost_empty asserts when count <= this value

- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- write  input  1  push request
- data_in  input  DATA_WIDTH  push data
- read  input  1  pop request
- data_out  output  DATA_WIDTH  pop data
- rd_valid  output  1  data_out holds a newly popped word (standard mode only)
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AFULL_THRESH
- almost_empty  output  1  count <= AEMPTY_THRESH
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: write attempted while full and not accepted
- underflow  output  1  sticky: read attempted while empty
- clear_err  input  1  synchronous clear of overflow/underflow

## Operation
- Storage: DEPTH x DATA_WIDTH array; wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide, with the MSB as the wrap bit. full = ptr indices equal and wrap bits differ; empty = pointers equal. Wrap-around is the natural roll-over of the index bits; no modulo logic.
- Write accepted (wr_en) = write && (!full || read_accepted). Read accepted (rd_en) = read && !empty.
- Simultaneous write and read when full: both accepted; count stays DEPTH; full stays asserted.
- Simultaneous write and read when empty: write accepted, read rejected and underflow set; count becomes 1.
- count: +1 on wr_en only, -1 on rd_en only, unchanged on both or neither. count is a register, not a pointer difference.
- All flags (full, empty, almost_*) are derived from registered count/pointers and are valid in the same cycle count updates.
- overflow sets on write && !wr_en; underflow sets on read && !rd_en. Both hold until clear_err or reset. If clear_err is asserted in the same cycle as a new error event, the set wins.
- Memory contents are not reset.

## Timing
- Reset values: data_out 0, rd_valid 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, and both pointers 0. Reset asserted mid-transfer discards all contents immediately and asynchronously.
- Write latency: data written on edge N is visible to a pop issued from edge N+1. empty deasserts after edge N.
- Standard mode: a pop at edge N registers data_out; rd_valid is high for the cycle after edge N only. data_out holds its value when there is no pop.
- Flag latency: all status outputs change one cycle after the edge that accepted the operation, with no extra pipeline delay.

## Configuration
- FIFO_FWFT_EN defined: first-word fall-through. data_out combinationally presents the head entry whenever !empty, and read acknowledges/pops it. rd_valid is tied to !empty. The data_out value while empty is don't-care (the bench must not check it).
- FIFO_FWFT_EN undefined: standard registered read as described in Timing.

## Test plan
- Reset, then with DEPTH=8 push 8 words 0x01..0x08 -> full=1, count=8, almost_full=1 (AFULL_THRESH=4); a 9th write -> overflow=1, count stays 8, contents unchanged.
- Pop all 8 words in standard mode -> data_out 0x01..0x08 each appearing one cycle after its read with rd_valid high; empty=1 after the last pop; a further read -> underflow=1.
- Full FIFO with write and read in the same cycle (data_in=0xAA) -> count stays 8, full stays 1, and 0xAA is popped after 7 further pops (checks wrap-around).
- Empty FIFO with write and read in the same cycle -> count=1, underflow=1, and the next read returns the written word; clear_err then deasserts both error flags.
- Assert reset_n low mid-stream with count=5 -> outputs immediately take their reset values; after release, a push/pop of 0x5A returns 0x5A.
- With FIFO_FWFT_EN defined, push 0x11 -> data_out=0x11 and rd_valid=1 on the following cycle before any read; read -> empty=1.
